// File: rtl/hex_display_ctrl.sv
// Seven-segment display controller with a small register interface.
// A VALUE/CTRL register pair is snapshotted into a scan engine that
// refreshes one digit per clock through a single shared hex decoder.
// A free-running prescaler produces the blink phase and also schedules
// refresh scans so blinking digits follow the phase.
//
// Bus handshake: write and read are single-cycle strobes with no ready
// signal. A write updates the addressed register on the clock edge where
// write=1. A read latches the addressed register into readdata on the
// edge where read=1; readdata then holds until the next read.

// Active-low seven-segment decoder for one hexadecimal nibble
// (segment order dp,g,f,e,d,c,b,a; a 0 lights a segment).
module hexdecoder (
    input  logic [3:0] nibble,
    output logic [7:0] code
);

    // Pure lookup from nibble to segment pattern
    always_comb begin
        code = 8'hFF;
        case (nibble)
            4'h0: code = 8'hC0;
            4'h1: code = 8'hF9;
            4'h2: code = 8'hA4;
            4'h3: code = 8'hB0;
            4'h4: code = 8'h99;
            4'h5: code = 8'h92;
            4'h6: code = 8'h82;
            4'h7: code = 8'hF8;
            4'h8: code = 8'h80;
            4'h9: code = 8'h90;
            4'hA: code = 8'h88;
            4'hB: code = 8'h83;
            4'hC: code = 8'hC6;
            4'hD: code = 8'hA1;
            4'hE: code = 8'h86;
            4'hF: code = 8'h8E;
            default: code = 8'hFF;
        endcase
    end

endmodule

module hex_display_ctrl #(
    parameter int NDIGITS   = 6,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             address,
    input  logic                   write,
    input  logic [31:0]            writedata,
    input  logic                   read,
    output logic [31:0]            readdata,
    output logic [8*NDIGITS-1:0]   hex_out
);

    localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int CNTW = $clog2(BLINK_DIV);
    localparam int VW   = 4 * NDIGITS;

    localparam logic [1:0] ADDR_VALUE  = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Programmer-visible registers
    logic [VW-1:0]      value_reg;
    logic [NDIGITS-1:0] blank_mask;
    logic [NDIGITS-1:0] blink_mask;
    logic               enable;

    // Status and timing state
    logic [7:0]         frame_cnt;
    logic [CNTW-1:0]    presc;
    logic               blink_phase;
    logic               pending;

    // Scan engine state and the snapshot it works from
    state_t             state;
    logic [IDXW-1:0]    idx;
    logic [VW-1:0]      snap_value;
    logic [NDIGITS-1:0] snap_blank;
    logic [NDIGITS-1:0] snap_blink;
    logic               snap_enable;
    logic               snap_phase;

    // Combinational helpers
    logic               wr_value;
    logic               wr_ctrl;
    logic               blink_wrap;
    logic               scan_start;
    logic               last_digit;
    logic [3:0]         cur_nibble;
    logic [7:0]         dec_code;
    logic [7:0]         digit_code;
    logic [31:0]        value_word;
    logic [31:0]        ctrl_word;
    logic [31:0]        status_word;
    logic [31:0]        rd_mux;
    logic               unused_wdata;

    // Only some writedata bits land in registers; the rest are don't-care.
    assign unused_wdata = &{1'b0, writedata};

    assign wr_value   = write && (address == ADDR_VALUE);
    assign wr_ctrl    = write && (address == ADDR_CTRL);
    assign blink_wrap = (presc == CNTW'(BLINK_DIV - 1));
    assign scan_start = (state == IDLE) && pending;
    assign last_digit = (idx == IDXW'(NDIGITS - 1));
    assign cur_nibble = snap_value[{idx, 2'b00} +: 4];

    // The one decoder shared by all digits; it sees the digit under scan
    hexdecoder u_dec (
        .nibble (cur_nibble),
        .code   (dec_code)
    );

    // Pick the final code for the digit under scan: blanking wins over
    // blinking, which wins over the decoded nibble
    always_comb begin
        digit_code = dec_code;
        if (!snap_enable || snap_blank[idx]) begin
            digit_code = 8'hFF;
        end else if (snap_blink[idx] && snap_phase) begin
            digit_code = 8'hFF;
        end
    end

    // Assemble register images as seen by the bus; unused bits read 0
    always_comb begin
        value_word                = '0;
        value_word[VW-1:0]        = value_reg;
        ctrl_word                 = '0;
        ctrl_word[NDIGITS-1:0]    = blank_mask;
        ctrl_word[8 +: NDIGITS]   = blink_mask;
        ctrl_word[16]             = enable;
        status_word               = '0;
        status_word[0]            = (state == SCAN);
        status_word[1]            = pending;
        status_word[2]            = blink_phase;
        status_word[15:8]         = frame_cnt;
    end

    // Read address decode; the reserved address reads as zero
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_VALUE:  rd_mux = value_word;
            ADDR_CTRL:   rd_mux = ctrl_word;
            ADDR_STATUS: rd_mux = status_word;
            default:     rd_mux = '0;
        endcase
    end

    // Bus writes into VALUE and CTRL; STATUS and reserved writes are dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_reg  <= '0;
            blank_mask <= '0;
            blink_mask <= '0;
            enable     <= 1'b1;
        end else begin
            if (wr_value) begin
                value_reg <= writedata[VW-1:0];
            end
            if (wr_ctrl) begin
                blank_mask <= writedata[NDIGITS-1:0];
                blink_mask <= writedata[8 +: NDIGITS];
                enable     <= writedata[16];
            end
        end
    end

    // Registered read data, held between read strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (read) begin
            readdata <= rd_mux;
        end
    end

    // Free-running blink prescaler; each wrap flips the blink phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc       <= '0;
            blink_phase <= 1'b0;
        end else if (blink_wrap) begin
            presc       <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            presc <= presc + CNTW'(1);
        end
    end

    // Refresh request: any new event re-arms it even on the edge where a
    // scan consumes the previous request, so nothing is lost
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b1;
        end else begin
            pending <= (pending && !scan_start) || wr_value || wr_ctrl || blink_wrap;
        end
    end

    // Scan FSM: snapshot on start, then write one digit per clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            idx         <= '0;
            snap_value  <= '0;
            snap_blank  <= '0;
            snap_blink  <= '0;
            snap_enable <= 1'b0;
            snap_phase  <= 1'b0;
            frame_cnt   <= '0;
            hex_out     <= {NDIGITS{8'hFF}};
        end else begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        snap_value  <= value_reg;
                        snap_blank  <= blank_mask;
                        snap_blink  <= blink_mask;
                        snap_enable <= enable;
                        snap_phase  <= blink_phase;
                        idx         <= '0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    hex_out[{idx, 3'b000} +: 8] <= digit_code;
                    if (last_digit) begin
                        idx       <= '0;
                        frame_cnt <= frame_cnt + 8'd1;
                        state     <= IDLE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl. A six-digit instance with a
// very long blink period covers register access, scan timing and frame
// counting; a two-digit instance with BLINK_DIV=4 covers blinking.
module tb_hex_display_ctrl;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset_n;
    always #5 clk = ~clk;

    // six-digit instance
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic [47:0] hex_out;

    // two-digit fast-blink instance
    logic [1:0]  address_b;
    logic        write_b;
    logic [31:0] writedata_b;
    logic        read_b;
    logic [31:0] readdata_b;
    logic [15:0] hex_out_b;

    hex_display_ctrl #(.NDIGITS(6)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .read      (read),
        .readdata  (readdata),
        .hex_out   (hex_out)
    );

    hex_display_ctrl #(.NDIGITS(2), .BLINK_DIV(4)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address_b),
        .write     (write_b),
        .writedata (writedata_b),
        .read      (read_b),
        .readdata  (readdata_b),
        .hex_out   (hex_out_b)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] seg(input logic [3:0] n);
        logic [7:0] t [16];
        t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return t[n];
    endfunction

    function automatic logic [47:0] exp_hex(input logic [23:0] v);
        logic [47:0] r;
        for (int i = 0; i < 6; i++) r[8*i +: 8] = seg(v[4*i +: 4]);
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        step();
        write     = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] e, input string name);
        address = a;
        read    = 1'b1;
        exp_q.push_back(e);
        step();
        read    = 1'b0;
        if (exp_q.size() == 0) begin
            check({name, " queue"}, 64'd0, 64'd1);
        end else begin
            check(name, readdata, exp_q.pop_front());
        end
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        logic [31:0] ctrl_wr;
        logic [31:0] ctrl_rd;
        logic [47:0] hex;
    } ctrl_vec_t;

    ctrl_vec_t   vecs[6];
    logic [31:0] st_exp[9];
    logic [47:0] new_codes;
    logic [47:0] e_hex;
    logic [31:0] rv;

    // watchdog: the whole run is a few thousand cycles
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // VALUE = 0x0FEDCB while these run: d0 83 d1 C6 d2 A1 d3 86 d4 8E d5 C0
        vecs[0] = '{32'h0001_0005, 32'h0001_0005, 48'hC0_8E_86_FF_C6_FF};
        vecs[1] = '{32'h0000_0000, 32'h0000_0000, 48'hFF_FF_FF_FF_FF_FF};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0001_3F3F, 48'hFF_FF_FF_FF_FF_FF};
        vecs[3] = '{32'h0001_0020, 32'h0001_0020, 48'hFF_8E_86_A1_C6_83};
        vecs[4] = '{32'h0001_3F00, 32'h0001_3F00, 48'hC0_8E_86_A1_C6_83};
        vecs[5] = '{32'h0001_0000, 32'h0001_0000, 48'hC0_8E_86_A1_C6_83};
        // STATUS seen after edge E0+k of the VALUE write (frame count 1 before)
        st_exp[0] = 32'h0;
        st_exp[1] = 32'h0000_0102;
        for (int k = 2; k <= 7; k++) st_exp[k] = 32'h0000_0101;
        st_exp[8] = 32'h0000_0200;
        new_codes = 48'hC0_8E_86_A1_C6_83;

        reset_n = 1'b0;
        address = '0; write = 1'b0; writedata = '0; read = 1'b0;
        address_b = '0; write_b = 1'b0; writedata_b = '0; read_b = 1'b0;

        // ---- reset state and first frame ----
        repeat (3) step();
        check("reset_hex", hex_out, {6{8'hFF}});
        check("reset_readdata", readdata, 32'h0);
        reset_n = 1'b1;
        repeat (6) step();
        check("boot_partial", hex_out, 48'hFF_C0_C0_C0_C0_C0);
        step();
        check("boot_frame", hex_out, {6{8'hC0}});
        bus_read(2'd2, 32'h0000_0100, "boot_status");
        bus_read(2'd1, 32'h0001_0000, "boot_ctrl");
        bus_read(2'd0, 32'h0, "boot_value");
        bus_read(2'd3, 32'h0, "boot_reserved");

        // ---- digit latency and busy window ----
        bus_write(2'd0, 32'h000F_EDCB);
        address = 2'd2;
        read    = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back(st_exp[k]);
            step();
            check($sformatf("lat_status_k%0d", k), readdata, exp_q.pop_front());
            for (int i = 0; i < 6; i++) e_hex[8*i +: 8] = (k >= 2 + i) ? new_codes[8*i +: 8] : 8'hC0;
            check($sformatf("lat_hex_k%0d", k), hex_out, e_hex);
        end
        read = 1'b0;
        bus_read(2'd0, 32'h000F_EDCB, "value_readback");

        // ---- CTRL blank / enable / blink-mask table ----
        for (int v = 0; v < 6; v++) begin
            bus_write(2'd1, vecs[v].ctrl_wr);
            repeat (7) step();
            check($sformatf("ctrl_hex_%0d", v), hex_out, vecs[v].hex);
            bus_read(2'd1, vecs[v].ctrl_rd, $sformatf("ctrl_rd_%0d", v));
        end
        bus_read(2'd2, 32'h0000_0800, "ctrl_status");

        // ---- write during a scan: snapshot is kept, second scan follows ----
        bus_write(2'd0, 32'h0012_3456);
        repeat (2) step();
        bus_write(2'd0, 32'h0065_4321);
        repeat (4) step();
        check("mid_first_frame", hex_out, 48'hF9_A4_B0_99_92_82);
        step();
        check("mid_gap", hex_out, 48'hF9_A4_B0_99_92_82);
        repeat (2) step();
        check("mid_second_partial", hex_out, 48'hF9_A4_B0_99_A4_F9);
        repeat (4) step();
        check("mid_second_frame", hex_out, 48'h82_92_99_B0_A4_F9);
        bus_read(2'd2, 32'h0000_0A00, "mid_status");

        // ---- reset during a scan ----
        bus_write(2'd0, 32'h00AB_CDEF);
        bus_read(2'd2, 32'h0000_0A02, "rst_pre_status");
        repeat (3) step();
        check("rst_pre_hex", hex_out, 48'h82_92_99_A1_86_8E);
        reset_n = 1'b0;
        #1;
        check("rst_async_hex", hex_out, {6{8'hFF}});
        check("rst_async_readdata", readdata, 32'h0);
        repeat (2) step();
        check("rst_hold_hex", hex_out, {6{8'hFF}});
        reset_n = 1'b1;
        repeat (7) step();
        check("rst_fresh_frame", hex_out, {6{8'hC0}});
        bus_read(2'd2, 32'h0000_0100, "rst_status");
        bus_read(2'd0, 32'h0, "rst_value");

        // ---- frame counter wrap with random values ----
        rv = '0;
        for (int n = 0; n < 255; n++) begin
            rv = $urandom();
            bus_write(2'd0, rv);
            repeat (7) step();
            check($sformatf("wrap_hex_%0d", n), hex_out, exp_hex(rv[23:0]));
            if (n == 253) bus_read(2'd2, 32'h0000_FF00, "wrap_status_255");
        end
        bus_read(2'd2, 32'h0000_0000, "wrap_status_0");

        // ---- ignored writes ----
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_write(2'd3, 32'hFFFF_FFFF);
        repeat (3) step();
        bus_read(2'd2, 32'h0000_0000, "ign_status");
        check("ign_hex", hex_out, exp_hex(rv[23:0]));
        bus_read(2'd1, 32'h0001_0000, "ign_ctrl");
        bus_read(2'd0, {8'h00, rv[23:0]}, "ign_value");
        bus_read(2'd3, 32'h0, "ign_reserved");

        // ---- blinking on the BLINK_DIV=4 instance ----
        reset_n = 1'b0;
        repeat (2) step();
        reset_n     = 1'b1;
        address_b   = 2'd1;
        writedata_b = 32'h0001_0100;
        write_b     = 1'b1;
        step();
        write_b   = 1'b0;
        address_b = 2'd2;
        read_b    = 1'b1;
        for (int k = 2; k <= 49; k++) begin
            step();
            check($sformatf("blink_phase_k%0d", k), readdata_b[2], 64'(((k - 1) / 4) % 2));
            if (k >= 18) begin
                check($sformatf("blink_d0_k%0d", k), hex_out_b[7:0],
                      (((k - 18) / 4) % 2 == 0) ? 64'hC0 : 64'hFF);
                check($sformatf("blink_d1_k%0d", k), hex_out_b[15:8], 64'hC0);
            end
        end
        read_b = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 SHALL have parameter NDIGITS, default 6, number of seven-segment digits driven.
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, clock cycles per blink half-period; must be at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, reset; asynchronous assert, active-low.
REQ-005 SHALL have port address, input, 2, register select: 0 VALUE, 1 CTRL, 2 STATUS, 3 reserved.
REQ-006 SHALL have port write, input, 1, write strobe, sampled each clk edge.
REQ-007 SHALL have port writedata, input, 32, write data.
REQ-008 SHALL have port read, input, 1, read strobe.
REQ-009 SHALL have port readdata, output, 32, registered read data.
REQ-010 SHALL have port hex_out, output, 8*NDIGITS, active-low segment codes; digit i is hex_out[8i+7:8i].

Function
REQ-011 SHALL hold a VALUE register with bits [4*NDIGITS-1:0]; digit i displays nibble VALUE[4i+3:4i]; upper bits read as 0.
REQ-012 SHALL hold a CTRL register: bits [NDIGITS-1:0] blank mask, bits [8+NDIGITS-1:8] blink mask, bit 16 enable; other bits read as 0.
REQ-013 SHALL expose STATUS: bit 0 busy (state is SCAN), bit 1 pending, bit 2 blink phase, bits [15:8] frame count; writes to STATUS and to address 3 are ignored.
REQ-014 SHALL update the written register on the edge where write=1; readdata SHALL be valid one cycle after the edge where read=1 and SHALL hold its value otherwise; address 3 reads 0.
REQ-015 SHALL set pending on any write to VALUE or CTRL and on every blink toggle; coincident events SHALL set pending only once.
REQ-016 SHALL run a two-state FSM: IDLE and SCAN.
REQ-017 In IDLE with pending=1, it SHALL on the next edge snapshot VALUE and CTRL, clear pending, set idx=0 and enter SCAN.
REQ-018 In SCAN it SHALL process one digit per cycle through one shared hexdecoder instance, so that hex_out digit idx is written on the edge that ends that cycle. After idx=NDIGITS-1 it SHALL return to IDLE and increment frame count, wrapping 255 to 0.
REQ-019 Latency: a write at edge E0 SHALL update digit i at edge E0+2+i when the FSM is IDLE at E0.
REQ-020 A write during SCAN SHALL NOT affect the scan in progress, because that scan uses its snapshot. Pending stays set, and a new scan SHALL start on the first edge after the return to IDLE.
REQ-021 Digit code selection:
- enable=0 or blank bit set: 8'hFF.
- else blink bit set and blink phase=1: 8'hFF.
- else the hexdecoder output (digit 0 -> 8'hC0, 8 -> 8'h80, F -> 8'h8E).
REQ-022 The blink prescaler SHALL count 0..BLINK_DIV-1 continuously. On wrap it SHALL toggle blink phase and set pending, independent of the FSM state.
REQ-023 Digits not being written in a given cycle SHALL hold their previous codes; hex_out SHALL never show a partially decoded code.

Reset
REQ-024 On reset_n=0, the block SHALL immediately set hex_out to all 8'hFF, readdata=0, VALUE=0, CTRL=32'h0001_0000, frame count=0, prescaler=0, blink phase=0, state=IDLE, idx=0 and pending=1.
REQ-025 A reset during SCAN SHALL abort the scan with no further digit updates. After release, the first edge SHALL start a fresh scan, per REQ-017.

Verification
REQ-026 Release reset (NDIGITS=6) -> after 7 edges, all digits = 8'hC0; frame count=1; busy=0.
REQ-027 Write VALUE=0x0FEDCB at edge E0 with the FSM idle:
- digit0 = 8'h83 at E0+2.
- digit5 = 8'hC0 at E0+7.
- busy=1 from E0+1 to E0+7.
REQ-028 Write CTRL=0x0001_0005, then CTRL=0 -> digits 0 and 2 = 8'hFF with the others decoded; then all digits = 8'hFF.
REQ-029 Run with BLINK_DIV=4 and CTRL=0x0001_0100 -> digit0 alternates decoded/8'hFF every 4 cycles (plus scan latency) and the phase bit toggles in STATUS.
REQ-030 Write VALUE mid-scan, then assert reset_n=0 mid-scan:
- The current scan completes with the old value; a second scan shows the new value; frame count rises by 2.
- The reset mid-scan forces hex_out to all 8'hFF immediately.
REQ-031 Force 256 frames -> frame count wraps to 0; reads of address 3 and writes to STATUS leave state unchanged.
